// File: rtl/blin_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// blin_seq : sequences a PAR-wide binary FC datapath over a full output layer.
// Optional perf counters: BLIN_SEQ_PERF_EN.   Rev 1.0
// ============================================================================
module blin_seq #(
  parameter int ISIZE_FEAT = 64,
  parameter int OSIZE_FEAT = 32,
  parameter int PAR        = 8,
  parameter int N_BITCONV  = 7,
  parameter int AW         = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ISIZE_FEAT-1:0]     in_data_i,
  input  logic [AW-1:0]             cfg_base_i,
  output logic                      mem_req_o,
  output logic [AW-1:0]             mem_addr_o,
  input  logic [PAR*ISIZE_FEAT-1:0] mem_w_i,
  input  logic [PAR*N_BITCONV-1:0]  mem_thr_i,
  input  logic [PAR*2-1:0]          mem_sign_i,
  output logic [ISIZE_FEAT-1:0]     dp_layer_o,
  output logic [PAR*ISIZE_FEAT-1:0] dp_weights_o,
  output logic [PAR*N_BITCONV-1:0]  dp_threshold_o,
  output logic [PAR*2-1:0]          dp_sign_o,
  input  logic [PAR-1:0]            dp_res_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OSIZE_FEAT-1:0]     out_data_o,
`ifdef BLIN_SEQ_PERF_EN
  output logic [15:0]               perf_frames_o,
  output logic [15:0]               perf_stall_o,
`endif
  output logic                      busy_o
);

  localparam int            G      = OSIZE_FEAT / PAR;
  localparam logic [AW-1:0] G_LAST = AW'(G - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           g_q, g_d;
  logic [AW-1:0]           base_q, base_d;
  logic [AW-1:0]           cap_g_q;
  logic                    cap_q;
  logic [ISIZE_FEAT-1:0]   layer_q, layer_d;
  logic [OSIZE_FEAT-1:0]   out_q, out_d;
  logic                    accept;
  logic                    out_hs;

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    base_d      = base_q;
    layer_d     = layer_q;
    out_d       = out_q;
    // An abort request must not be acknowledged as an accepted frame.
    in_ready_o  = (state_q == S_IDLE) && !clear_i;
    accept      = in_valid_i && in_ready_o;
    mem_req_o   = (state_q == S_RUN);
    out_valid_o = (state_q == S_DONE);
    out_hs      = out_valid_o && out_ready_i;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          layer_d = in_data_i;
          base_d  = cfg_base_i;
          g_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        g_d = g_q + 1'b1;
        if (g_q == G_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) state_d = S_IDLE;

    // Group 0 lands in the MSBs of the output vector.
    if (cap_q && !clear_i) begin
      for (int i = 0; i < G; i++) begin
        if (cap_g_q == AW'(i)) out_d[OSIZE_FEAT-1-i*PAR -: PAR] = dp_res_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      base_q  <= '0;
      cap_q   <= 1'b0;
      cap_g_q <= '0;
      layer_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      base_q  <= base_d;
      cap_q   <= mem_req_o && !clear_i;
      cap_g_q <= g_q;
      layer_q <= layer_d;
      out_q   <= out_d;
    end
  end

  assign mem_addr_o     = base_q + g_q;
  assign dp_layer_o     = layer_q;
  assign dp_weights_o   = mem_w_i;
  assign dp_threshold_o = mem_thr_i;
  assign dp_sign_o      = mem_sign_i;
  assign out_data_o     = out_q;
  assign busy_o         = (state_q != S_IDLE);

`ifdef BLIN_SEQ_PERF_EN
  logic [15:0] frames_q, stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_hs) frames_q <= frames_q + 16'd1;
      if (out_valid_o && !out_ready_i) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_frames_o = frames_q;
  assign perf_stall_o  = stall_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blin_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_blin_seq : directed self-checking bench for blin_seq (G = 4).   Rev 1.0
// ============================================================================
module tb_blin_seq;

  localparam int ISZ = 64;
  localparam int OSZ = 32;
  localparam int PAR = 8;
  localparam int NB  = 7;
  localparam int AW  = 8;
  localparam int G   = OSZ / PAR;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               clear     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [ISZ-1:0]     in_data   = '0;
  logic [AW-1:0]      cfg_base  = '0;
  logic               mem_req;
  logic [AW-1:0]      mem_addr;
  logic [PAR*ISZ-1:0] mem_w;
  logic [PAR*NB-1:0]  mem_thr;
  logic [PAR*2-1:0]   mem_sign;
  logic [ISZ-1:0]     dp_layer;
  logic [PAR*ISZ-1:0] dp_w;
  logic [PAR*NB-1:0]  dp_thr;
  logic [PAR*2-1:0]   dp_sign;
  logic [PAR-1:0]     dp_res;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OSZ-1:0]     out_data;
  logic               busy;
`ifdef BLIN_SEQ_PERF_EN
  logic [15:0]        perf_frames;
  logic [15:0]        perf_stall;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_frames = 0;
  int          exp_stall  = 0;
  int          mode = 0;
  logic [7:0]  cur_base = '0;
  logic [7:0]  pat [4];
  logic [7:0]  mem_addr_q = '0;

  blin_seq #(
    .ISIZE_FEAT(ISZ), .OSIZE_FEAT(OSZ), .PAR(PAR), .N_BITCONV(NB), .AW(AW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .cfg_base_i     (cfg_base),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_w_i        (mem_w),
    .mem_thr_i      (mem_thr),
    .mem_sign_i     (mem_sign),
    .dp_layer_o     (dp_layer),
    .dp_weights_o   (dp_w),
    .dp_threshold_o (dp_thr),
    .dp_sign_o      (dp_sign),
    .dp_res_i       (dp_res),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
`ifdef BLIN_SEQ_PERF_EN
    .perf_frames_o  (perf_frames),
    .perf_stall_o   (perf_stall),
`endif
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wgt(input logic [7:0] a, input int j);
    logic [31:0] k;
    k = {24'd0, a} * 32'd8 + 32'(j) + 32'd1;
    return {k * 32'h9E3779B9, (k ^ 32'h5BD1E995) * 32'h85EBCA6B};
  endfunction

  function automatic logic [6:0] thr(input logic [7:0] a, input int j);
    return 7'(28 + ((int'(a) + j) % 9));
  endfunction

  // Golden layer result: neuron j of group g sits at bit (G-1-g)*PAR + j.
  function automatic logic [31:0] gold(input logic [63:0] vec, input logic [7:0] base);
    logic [31:0] r;
    logic [7:0]  a;
    r = '0;
    for (int g = 0; g < G; g++) begin
      a = base + 8'(g);
      for (int j = 0; j < PAR; j++)
        r[(G-1-g)*PAR + j] = ($countones(~(vec ^ wgt(a, j))) >= int'(thr(a, j)));
    end
    return r;
  endfunction

  // Synchronous parameter memory: data follows the request by one cycle.
  always @(posedge clk) if (mem_req) mem_addr_q <= mem_addr;

  always_comb begin
    mem_w    = '0;
    mem_thr  = '0;
    mem_sign = '0;
    for (int j = 0; j < PAR; j++) begin
      mem_w[j*ISZ +: ISZ] = wgt(mem_addr_q, j);
      mem_thr[j*NB +: NB] = thr(mem_addr_q, j);
      mem_sign[j*2 +: 2]  = 2'(j);
    end
  end

  logic [7:0] grp_off;
  always_comb begin
    dp_res  = '0;
    grp_off = mem_addr_q - cur_base;
    if (mode == 0) begin
      for (int j = 0; j < PAR; j++)
        dp_res[j] = ($countones(~(dp_layer ^ dp_w[j*ISZ +: ISZ])) >= int'(dp_thr[j*NB +: NB]));
    end else begin
      dp_res = pat[grp_off[1:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] base, input logic [63:0] vec, input int md,
                           input logic [31:0] exp, input int stall);
    @(negedge clk);
    mode = md; cur_base = base;
    in_data = vec; cfg_base = base; in_valid = 1'b1; out_ready = (stall == 0);
    #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
    for (int k = 1; k <= G; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = ~vec; cfg_base = ~base;
      #1;
      chk("mem_req_run", 64'(mem_req), 64'd1);
      chk("mem_addr", 64'(mem_addr), 64'(8'(base + 8'(k - 1))));
      chk("in_ready_run", 64'(in_ready), 64'd0);
      chk("dp_layer", dp_layer, vec);
    end
    @(negedge clk); #1;
    chk("mem_req_drain", 64'(mem_req), 64'd0);
    chk("valid_drain", 64'(out_valid), 64'd0);
    chk("busy_drain", 64'(busy), 64'd1);
    @(negedge clk); #1;
    chk("valid_done", 64'(out_valid), 64'd1);
    chk("out_data", 64'(out_data), 64'(exp));
    chk("in_ready_done", 64'(in_ready), 64'd0);
    for (int s = 1; s < stall; s++) begin
      @(negedge clk); #1;
      chk("valid_stall", 64'(out_valid), 64'd1);
      chk("data_stall", 64'(out_data), 64'(exp));
      chk("in_ready_stall", 64'(in_ready), 64'd0);
    end
    if (stall > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("valid_release", 64'(out_valid), 64'd1);
    end
    exp_stall += stall;
    exp_frames++;
    @(negedge clk); #1;
    chk("valid_after_hs", 64'(out_valid), 64'd0);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("busy_after_hs", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_dp_layer"}, dp_layer, 64'd0);
  endtask

  initial begin
    pat[0] = 8'hA5; pat[1] = 8'hA5; pat[2] = 8'hA5; pat[3] = 8'hA5;
    @(negedge clk); #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'h10, 64'hDEADBEEF_01234567, 0, gold(64'hDEADBEEF_01234567, 8'h10), 0);
    run_frame(8'h10, 64'h0F0F0F0F_F0F0F0F0, 1, 32'hA5A5A5A5, 0);
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h00; pat[3] = 8'hFF;
    run_frame(8'h40, 64'h12345678_9ABCDEF0, 1, 32'h00FF00FF, 5);
`ifdef BLIN_SEQ_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'(exp_stall));
    chk("perf_frames", 64'(perf_frames), 64'(exp_frames));
`endif
    run_frame(8'hFE, 64'hCAFEF00D_55AA33CC, 0, gold(64'hCAFEF00D_55AA33CC, 8'hFE), 0);

    // Abort in cycle 2 of a frame.
    @(negedge clk);
    mode = 0; cur_base = 8'h20; in_data = 64'h1; cfg_base = 8'h20;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); clear = 1'b1;
    #1 chk("clr_req_c2", 64'(mem_req), 64'd1);
    @(negedge clk); clear = 1'b0;
    #1;
    chk("clr_req_c3", 64'(mem_req), 64'd0);
    chk("clr_busy_c3", 64'(busy), 64'd0);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk); #1 chk("clr_no_valid", 64'(out_valid), 64'd0);
    end
    run_frame(8'h33, 64'hA5A5A5A5_00FF00FF, 0, gold(64'hA5A5A5A5_00FF00FF, 8'h33), 0);

    // Asynchronous reset during RUN.
    @(negedge clk);
    mode = 0; cur_base = 8'h50; in_data = 64'h77; cfg_base = 8'h50;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1 chk("arst_pre_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals("arst");
`ifdef BLIN_SEQ_PERF_EN
    chk("arst_perf_frames", 64'(perf_frames), 64'd0);
`endif
    exp_frames = 0;
    exp_stall  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h08, 64'h0123456789ABCDEF, 0, gold(64'h0123456789ABCDEF, 8'h08), 0);
`ifdef BLIN_SEQ_PERF_EN
    chk("perf_frames_post", 64'(perf_frames), 64'(exp_frames));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
